host_cmd_regs: RTL and testbench

Host-facing register block that sits directly upstream of the tensor-core control unit. Software stages one GEMM command in registers (matrix lengths plus four SRAM base addresses) and rings a doorbell. The block validates the staged command, packs it into the 64-bit command word, and buffers it in a 4-entry issue queue drained over a valid/ready handshake. It also counts completions from the control unit's done pulse and raises a maskable, sticky interrupt.

---
 rtl/host_cmd_regs.sv | 170 +++++++++++++++++
 tb/tb_host_cmd_regs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_regs.sv
// Host register block: stages one GEMM command, validates and packs it on doorbell,
// buffers it in a small issue queue, and tracks completions with a sticky interrupt.
module host_cmd_regs #(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int QUEUE_DEPTH          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr_en,
    input  logic        reg_rd_en,
    input  logic [3:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rdata_valid,
    output logic        cmd_valid,
    output logic [63:0] cmd_data,
    input  logic        cmd_ready,
    input  logic        cu_busy,
    input  logic        cu_done,
    output logic        irq
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] LEN_MAX = 8'(SYSTOLIC_ARRAY_WIDTH);

    typedef enum logic [3:0] {
        REG_LEN      = 4'd0,
        REG_ADDR_AB  = 4'd1,
        REG_ADDR_CD  = 4'd2,
        REG_DOORBELL = 4'd3,
        REG_STATUS   = 4'd4,
        REG_IRQ_CLR  = 4'd5,
        REG_IRQ_EN   = 4'd6
    } reg_idx_e;

    logic [7:0]            len_m, len_k, len_n;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c, addr_d;
    logic                  irq_en, irq_pending, overflow, len_err;
    logic [7:0]            issued_cnt, done_cnt;

    logic [63:0]           queue_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;

    logic        doorbell, len_ok, q_full, push, pop;
    logic [2:0]  w1c;
    logic [63:0] cmd_word;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^reg_wdata[31:26];

    assign doorbell = reg_wr_en && (reg_addr == REG_DOORBELL);
    assign w1c      = (reg_wr_en && (reg_addr == REG_IRQ_CLR)) ? reg_wdata[2:0] : 3'b000;
    assign len_ok   = (len_k != 8'd0) && (len_k <= LEN_MAX) &&
                      (len_n != 8'd0) && (len_n <= LEN_MAX);
    assign q_full   = (count == CNT_W'(QUEUE_DEPTH));
    assign cmd_valid = (count != '0);
    assign pop      = cmd_valid && cmd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign push     = doorbell && len_ok && (!q_full || pop);
    assign cmd_word = {addr_d, addr_c, addr_b, addr_a, len_n, len_k, len_m};
    assign cmd_data = queue_mem[rd_ptr];
    assign irq      = irq_pending & irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_m       <= '0;
            len_k       <= '0;
            len_n       <= '0;
            addr_a      <= '0;
            addr_b      <= '0;
            addr_c      <= '0;
            addr_d      <= '0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            overflow    <= 1'b0;
            len_err     <= 1'b0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
        end else begin
            if (reg_wr_en) begin
                case (reg_addr)
                    REG_LEN: begin
                        len_m <= reg_wdata[7:0];
                        len_k <= reg_wdata[15:8];
                        len_n <= reg_wdata[23:16];
                    end
                    REG_ADDR_AB: begin
                        addr_a <= reg_wdata[ADDR_WIDTH-1:0];
                        addr_b <= reg_wdata[16 +: ADDR_WIDTH];
                    end
                    REG_ADDR_CD: begin
                        addr_c <= reg_wdata[ADDR_WIDTH-1:0];
                        addr_d <= reg_wdata[16 +: ADDR_WIDTH];
                    end
                    REG_IRQ_EN: irq_en <= reg_wdata[0];
                    default: ;
                endcase
            end
            if (cu_done)     irq_pending <= 1'b1;
            else if (w1c[0]) irq_pending <= 1'b0;
            if (doorbell && len_ok && q_full && !pop) overflow <= 1'b1;
            else if (w1c[1])                          overflow <= 1'b0;
            if (doorbell && !len_ok) len_err <= 1'b1;
            else if (w1c[2])         len_err <= 1'b0;
            if (pop)     issued_cnt <= issued_cnt + 8'd1;
            if (cu_done) done_cnt   <= done_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) queue_mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                queue_mem[wr_ptr] <= cmd_word;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_LEN: rd_mux[23:0] = {len_n, len_k, len_m};
            REG_ADDR_AB: begin
                rd_mux[ADDR_WIDTH-1:0]  = addr_a;
                rd_mux[16 +: ADDR_WIDTH] = addr_b;
            end
            REG_ADDR_CD: begin
                rd_mux[ADDR_WIDTH-1:0]  = addr_c;
                rd_mux[16 +: ADDR_WIDTH] = addr_d;
            end
            REG_STATUS: begin
                rd_mux[0]         = cu_busy;
                rd_mux[1]         = irq_pending;
                rd_mux[2 +: CNT_W] = count;
                rd_mux[5]         = overflow;
                rd_mux[6]         = len_err;
                rd_mux[15:8]      = issued_cnt;
                rd_mux[23:16]     = done_cnt;
            end
            REG_IRQ_EN: rd_mux[0] = irq_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata       <= '0;
            reg_rdata_valid <= 1'b0;
        end else begin
            reg_rdata_valid <= reg_rd_en;
            if (reg_rd_en) reg_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_host_cmd_regs.sv
// Directed bench for host_cmd_regs; issued commands are checked against a queue of
// expected packed words as the control-unit handshake completes.
module tb_host_cmd_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_wr_en = 1'b0;
    logic        reg_rd_en = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_rdata_valid;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic        cmd_ready = 1'b0;
    logic        cu_busy = 1'b0;
    logic        cu_done = 1'b0;
    logic        irq;

    host_cmd_regs #(.ADDR_WIDTH(10), .SYSTOLIC_ARRAY_WIDTH(16), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rdata_valid(reg_rdata_valid),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .cu_busy(cu_busy), .cu_done(cu_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int exp_issued = 0;
    int exp_done   = 0;
    logic [63:0] exp_q [$];

    logic [7:0] s_m = '0, s_k = '0, s_n = '0;
    logic [9:0] s_a = '0, s_b = '0, s_c = '0, s_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_cmd();
        return {s_d, s_c, s_b, s_a, s_n, s_k, s_m};
    endfunction

    function automatic logic [31:0] status(input logic busy, input logic pend,
                                           input logic [2:0] cnt, input logic ovf, input logic lerr);
        logic [7:0] iss = 8'(exp_issued);
        logic [7:0] dn  = 8'(exp_done);
        return {8'h00, dn, iss, 1'b0, lerr, ovf, cnt, pend, busy};
    endfunction

    // Handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) chk("unexpected_cmd_valid", cmd_valid, 0);
            else chk("cmd_data", cmd_data, exp_q.pop_front());
            exp_issued++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        reg_rd_en = 1'b1; reg_addr = a;
        tick();
        reg_rd_en = 1'b0;
        chk({tag, "_valid"}, reg_rdata_valid, 1);
        chk(tag, reg_rdata, exp);
    endtask

    task automatic set_len(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n);
        s_m = m; s_k = k; s_n = n;
        wr(4'd0, {8'h00, n, k, m});
    endtask

    task automatic ring(input logic expect_push);
        if (expect_push) exp_q.push_back(pack_cmd());
        wr(4'd3, 32'h0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 0);
        chk({tag, "_valid_low"}, cmd_valid, 0);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_rdata", reg_rdata, 0);
        chk("rst_rdata_valid", reg_rdata_valid, 0);
        chk("rst_irq", irq, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        rd_chk("rst_status", 4'd4, 32'h0);

        // Single command, consumed immediately
        cmd_ready = 1'b1;
        set_len(8'h08, 8'h10, 8'h10);
        s_a = 10'h000; s_b = 10'h040; wr(4'd1, 32'h0040_0000);
        s_c = 10'h080; s_d = 10'h0C0; wr(4'd2, 32'h00C0_0080);
        rd_chk("len_rd", 4'd0, 32'h0010_1008);
        rd_chk("doorbell_rd", 4'd3, 32'h0);
        rd_chk("unmapped_rd", 4'd7, 32'h0);
        ring(1'b1);
        chk("t1_valid_high", cmd_valid, 1);
        chk("t1_cmd_word", cmd_data, 64'h3008_0100_0010_1008);
        tick();
        chk("t1_valid_one_cycle", cmd_valid, 0);
        rd_chk("t1_status", 4'd4, status(0, 0, 3'd0, 0, 0));

        // Same-cycle read and write returns the old value; unused bits read 0
        reg_wr_en = 1'b1; reg_rd_en = 1'b1; reg_addr = 4'd0; reg_wdata = 32'hFFFF_FFFF;
        tick();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        chk("rw_same_cycle", reg_rdata, 32'h0010_1008);
        rd_chk("len_masked", 4'd0, 32'h00FF_FFFF);
        wr(4'd1, 32'hFFFF_FFFF);
        rd_chk("addr_ab_masked", 4'd1, 32'h03FF_03FF);
        s_a = 10'h011; s_b = 10'h122; wr(4'd1, {6'h0, s_b, 6'h0, s_a});

        // Fill queue, overflow on the fifth, then drain in order
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_len(8'(i), 8'(i + 1), 8'(i + 2));
            ring(i < 4);
        end
        rd_chk("t2_status_full", 4'd4, status(0, 0, 3'd4, 1, 0));
        chk("t2_valid_held", cmd_valid, 1);
        cmd_ready = 1'b1;
        drain("t2");
        chk("t2_issued", 64'(exp_issued), 5);
        wr(4'd5, 32'h2);
        rd_chk("t2_ovf_cleared", 4'd4, status(0, 0, 3'd0, 0, 0));

        // Length validation at both bounds
        set_len(8'h01, 8'h00, 8'h01);
        ring(1'b0);
        chk("t3_k0_no_valid", cmd_valid, 0);
        rd_chk("t3_k0_status", 4'd4, status(0, 0, 3'd0, 0, 1));
        wr(4'd5, 32'h4);
        rd_chk("t3_lerr_clr1", 4'd4, status(0, 0, 3'd0, 0, 0));
        set_len(8'h01, 8'h01, 8'd17);
        ring(1'b0);
        chk("t3_n17_no_valid", cmd_valid, 0);
        rd_chk("t3_n17_status", 4'd4, status(0, 0, 3'd0, 0, 1));
        wr(4'd5, 32'h4);
        rd_chk("t3_lerr_clr2", 4'd4, status(0, 0, 3'd0, 0, 0));

        // Interrupt: set wins over same-cycle clear, masking by irq_en
        cu_busy = 1'b1;
        wr(4'd6, 32'h1);
        rd_chk("irq_en_rd", 4'd6, 32'h1);
        cu_done = 1'b1; tick(); cu_done = 1'b0; exp_done++;
        chk("t4_irq_set", irq, 1);
        cu_done = 1'b1; reg_wr_en = 1'b1; reg_addr = 4'd5; reg_wdata = 32'h1;
        tick();
        cu_done = 1'b0; reg_wr_en = 1'b0; exp_done++;
        chk("t4_irq_set_wins", irq, 1);
        rd_chk("t4_status", 4'd4, status(1, 1, 3'd0, 0, 0));
        wr(4'd5, 32'h1);
        chk("t4_irq_cleared", irq, 0);
        wr(4'd6, 32'h0);
        cu_done = 1'b1; tick(); cu_done = 1'b0; exp_done++;
        chk("t4_irq_masked", irq, 0);
        rd_chk("t4_masked_pending", 4'd4, status(1, 1, 3'd0, 0, 0));
        wr(4'd5, 32'h1);
        cu_busy = 1'b0;

        // Doorbell into a full queue with a same-cycle pop is accepted
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_len(8'(8'h20 + i), 8'd16, 8'(i + 1));
            ring(1'b1);
        end
        set_len(8'h55, 8'd3, 8'd4);
        exp_q.push_back(pack_cmd());
        cmd_ready = 1'b1; reg_wr_en = 1'b1; reg_addr = 4'd3; reg_wdata = 32'h0;
        tick();
        cmd_ready = 1'b0; reg_wr_en = 1'b0;
        rd_chk("t5_status", 4'd4, status(0, 0, 3'd4, 0, 0));
        cmd_ready = 1'b1;
        drain("t5");
        chk("t5_issued", 64'(exp_issued), 10);

        // Asynchronous reset with commands pending
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_len(8'(i), 8'd2, 8'd2);
            ring(1'b1);
        end
        chk("t6_valid_before", cmd_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid_async", cmd_valid, 0);
        chk("t6_data_async", cmd_data, 0);
        exp_q.delete();
        exp_issued = 0;
        exp_done   = 0;
        tick();
        rst = 1'b0;
        tick();
        rd_chk("t6_status", 4'd4, 32'h0);
        rd_chk("t6_len", 4'd0, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
